// File: rtl/vram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter_if
// Bundles the two requester ports (CPU, DMA), the shared VRAM port A lines
// and the arbiter debug view into one interface.
//
// Handshake: a requester raises *_req with *_rw/*_address/*_data_in and holds
// all four stable until it sees *_grant high in the same cycle; the beat is
// transferred on the rising edge that ends that cycle. Reads return one cycle
// later as a single-cycle *_data_valid pulse with *_data_out; writes return
// nothing.
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters plus the VRAM port A model)
//
// Debug: dbg_owner encodes the previous-cycle owner (0 = none, 1 = CPU,
// 2 = DMA); dbg_burst_count is the saturating burst counter.
// ---------------------------------------------------------------------------
interface vram_port_arbiter_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16
);
   logic                     cpu_req;
   logic                     cpu_rw;
   logic [ADDRESS_WIDTH-1:0] cpu_address;
   logic [DATA_WIDTH-1:0]    cpu_data_in;
   logic                     cpu_grant;
   logic [DATA_WIDTH-1:0]    cpu_data_out;
   logic                     cpu_data_valid;

   logic                     dma_req;
   logic                     dma_rw;
   logic [ADDRESS_WIDTH-1:0] dma_address;
   logic [DATA_WIDTH-1:0]    dma_data_in;
   logic                     dma_grant;
   logic [DATA_WIDTH-1:0]    dma_data_out;
   logic                     dma_data_valid;

   logic                     vram_enable;
   logic                     vram_rw;
   logic [ADDRESS_WIDTH-1:0] vram_address;
   logic [DATA_WIDTH-1:0]    vram_data_in;
   logic [DATA_WIDTH-1:0]    vram_data_out;

   logic [1:0]               dbg_owner;
   logic [7:0]               dbg_burst_count;

   modport slave (
      input  cpu_req, cpu_rw, cpu_address, cpu_data_in,
      output cpu_grant, cpu_data_out, cpu_data_valid,
      input  dma_req, dma_rw, dma_address, dma_data_in,
      output dma_grant, dma_data_out, dma_data_valid,
      output vram_enable, vram_rw, vram_address, vram_data_in,
      input  vram_data_out,
      output dbg_owner, dbg_burst_count
   );

   modport master (
      output cpu_req, cpu_rw, cpu_address, cpu_data_in,
      input  cpu_grant, cpu_data_out, cpu_data_valid,
      output dma_req, dma_rw, dma_address, dma_data_in,
      input  dma_grant, dma_data_out, dma_data_valid,
      input  vram_enable, vram_rw, vram_address, vram_data_in,
      output vram_data_out,
      input  dbg_owner, dbg_burst_count
   );
endinterface

// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
// Shares VRAM port A between the CPU path and the DMA/blitter engine, one
// single-beat transaction per cycle. Grant is combinational from the requests
// and registered owner/burst state; a burst limit bounds how long one side
// can hold the port while the other waits. Read data comes back one cycle
// after the grant on the side that issued the read.
//
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - vram_port_arbiter_if.slave (requesters, VRAM port A, debug)
// ---------------------------------------------------------------------------
module vram_port_arbiter #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int MAX_BURST     = 8
) (
   input  logic                clock,
   input  logic                reset,
   vram_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   typedef enum logic {
      TAG_CPU = 1'b0,
      TAG_DMA = 1'b1
   } tag_e;

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

   owner_e                   owner_q, owner_d;
   logic [7:0]               burst_count_q, burst_count_d;
   logic                     rd_pending_q, rd_pending_d;
   tag_e                     rd_tag_q, rd_tag_d;
   logic [DATA_WIDTH-1:0]    cpu_hold_q, cpu_hold_d;
   logic [DATA_WIDTH-1:0]    dma_hold_q, dma_hold_d;

   logic                     gnt_cpu;
   logic                     gnt_dma;
   logic                     at_limit;
   logic                     cpu_valid;
   logic                     dma_valid;
   logic                     sel_rw;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]    sel_data;

   assign at_limit = (burst_count_q >= MAX_BURST_C);

   // Grant decision. Gated by reset so nothing is granted while the block
   // is held in reset, even though requests may already be present.
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_dma = 1'b0;
      if (reset) begin
         if (bus.cpu_req && !bus.dma_req) begin
            gnt_cpu = 1'b1;
         end else if (bus.dma_req && !bus.cpu_req) begin
            gnt_dma = 1'b1;
         end else if (bus.cpu_req && bus.dma_req) begin
            unique case (owner_q)
               OWN_CPU: begin
                  gnt_cpu = !at_limit;
                  gnt_dma = at_limit;
               end
               OWN_DMA: begin
                  gnt_dma = !at_limit;
                  gnt_cpu = at_limit;
               end
               default: gnt_cpu = 1'b1;
            endcase
         end
      end
   end

   // Port A drive: granted requester's lines, otherwise all zero.
   always_comb begin
      sel_rw      = 1'b0;
      sel_address = '0;
      sel_data    = '0;
      if (gnt_cpu) begin
         sel_rw      = bus.cpu_rw;
         sel_address = bus.cpu_address;
         sel_data    = bus.cpu_data_in;
      end else if (gnt_dma) begin
         sel_rw      = bus.dma_rw;
         sel_address = bus.dma_address;
         sel_data    = bus.dma_data_in;
      end
   end

   // Owner / burst counter update and read tagging.
   always_comb begin
      owner_d       = OWN_NONE;
      burst_count_d = 8'd0;
      if (gnt_cpu || gnt_dma) begin
         owner_d = gnt_cpu ? OWN_CPU : OWN_DMA;
         if (owner_d == owner_q) begin
            burst_count_d = at_limit ? burst_count_q : burst_count_q + 8'd1;
         end else begin
            burst_count_d = 8'd1;
         end
      end
      rd_pending_d = (gnt_cpu || gnt_dma) && !sel_rw;
      rd_tag_d     = gnt_dma ? TAG_DMA : TAG_CPU;
   end

   // Read return: the RAM presents data the cycle after the read, so the
   // valid strobe is the pending flag itself and data_out passes the RAM
   // data through while valid, holding the captured value otherwise.
   always_comb begin
      cpu_valid  = rd_pending_q && (rd_tag_q == TAG_CPU);
      dma_valid  = rd_pending_q && (rd_tag_q == TAG_DMA);
      cpu_hold_d = cpu_valid ? bus.vram_data_out : cpu_hold_q;
      dma_hold_d = dma_valid ? bus.vram_data_out : dma_hold_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner_q       <= OWN_NONE;
         burst_count_q <= 8'd0;
         rd_pending_q  <= 1'b0;
         rd_tag_q      <= TAG_CPU;
         cpu_hold_q    <= '0;
         dma_hold_q    <= '0;
      end else begin
         owner_q       <= owner_d;
         burst_count_q <= burst_count_d;
         rd_pending_q  <= rd_pending_d;
         rd_tag_q      <= rd_tag_d;
         cpu_hold_q    <= cpu_hold_d;
         dma_hold_q    <= dma_hold_d;
      end
   end

   assign bus.cpu_grant       = gnt_cpu;
   assign bus.dma_grant       = gnt_dma;
   assign bus.vram_enable     = gnt_cpu || gnt_dma;
   assign bus.vram_rw         = sel_rw;
   assign bus.vram_address    = sel_address;
   assign bus.vram_data_in    = sel_data;
   assign bus.cpu_data_valid  = cpu_valid;
   assign bus.dma_data_valid  = dma_valid;
   assign bus.cpu_data_out    = cpu_hold_d;
   assign bus.dma_data_out    = dma_hold_d;
   assign bus.dbg_owner       = owner_q;
   assign bus.dbg_burst_count = burst_count_q;

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares VRAM port A between two requesters: the CPU memory-controller path and a DMA/blitter engine, on single-beat req/grant transactions. Sits between those requesters and `ram_dual_port_sync` port A. Grants one beat per cycle, drives the shared address/data/rw/enable lines and returns synchronous read data with a valid strobe. A burst limit keeps either requester from starving the other.

## Interface
- `ADDRESS_WIDTH`, 16, VRAM address width
- `DATA_WIDTH`, 16, VRAM word width
- `MAX_BURST`, 8, max consecutive grants to one requester while the other waits; legal range 1..255

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU requests a beat this cycle
- `cpu_rw`  in  1  1 = write, 0 = read
- `cpu_address`  in  ADDRESS_WIDTH  beat address
- `cpu_data_in`  in  DATA_WIDTH  write data
- `cpu_grant`  out  1  beat accepted this cycle
- `cpu_data_out`  out  DATA_WIDTH  read data
- `cpu_data_valid`  out  1  `cpu_data_out` valid for one cycle
- `dma_req`, `dma_rw`, `dma_address`, `dma_data_in`, `dma_grant`, `dma_data_out`, `dma_data_valid`: same as the `cpu_*` ports, for the DMA requester
- `vram_enable`  out  1  port A enable
- `vram_rw`  out  1  port A rw, 1 = write
- `vram_address`  out  ADDRESS_WIDTH  port A address
- `vram_data_in`  out  DATA_WIDTH  port A write data
- `vram_data_out`  in  DATA_WIDTH  port A read data, valid the cycle after the read

## Operation
- State registers:
  - `owner` (NONE/CPU/DMA): owner of the previous cycle's grant
  - `burst_count`: 8-bit, saturating at `MAX_BURST`
  - `rd_pending` (1 bit) and `rd_tag` (CPU/DMA)
- Grant decision is combinational from the requests and registered state. At most one grant per cycle:
  - Only one requester active: it is granted.
  - Both active, `owner`=NONE: CPU is granted.
  - Both active, `owner`=X, `burst_count` < `MAX_BURST`: X is granted.
  - Both active, `owner`=X, `burst_count` = `MAX_BURST`: the other requester is granted.
  - Neither active: no grant.
- State update per cycle:
  - Grant to the same owner: `burst_count` += 1, saturating.
  - Grant to a different owner: `owner` takes the new owner; `burst_count` = 1.
  - No grant: `owner`=NONE, `burst_count`=0.
- Port drive:
  - When granted, `vram_enable`=1 and `vram_rw`/`vram_address`/`vram_data_in` come from the granted requester.
  - When not granted, all port outputs are 0.
- Read return:
  - A granted read sets `rd_pending`=1 and `rd_tag`=granted side.
  - The next cycle, the tagged `*_data_valid`=1 and its `*_data_out` takes `vram_data_out`.
  - Each `*_data_out` holds its value between valids.
- Writes produce no valid strobe.
- A requester must hold its `req`/`rw`/`address`/`data` stable until it sees its grant.

## Timing
- Grant is same-cycle (zero latency) with respect to `req`.
- Writes commit at the rising edge that ends the grant cycle.
- Read data is valid 1 cycle after the grant. Back-to-back reads sustain one beat per cycle.
- Throughput is 1 beat/cycle total, shared between the requesters.
- Worst-case wait for a requester while the other streams: `MAX_BURST` cycles.
- `MAX_BURST`=1 gives strict alternation when both requesters are active.
- Reset (`reset`=0), asynchronous:
  - `owner`=NONE, `burst_count`=0, `rd_pending`=0, both `*_data_out`=0, both `*_data_valid`=0.
  - While `reset` is low: both grants=0, `vram_enable`=0, all `vram_*` outputs 0.
- Reset asserted with a read in flight: the valid is dropped and never delivered.
- Simultaneous events:
  - A read returning for one side and a new grant to the other side in the same cycle are independent and both proceed.
  - A request deasserted in the same cycle the burst limit is reached: no switch is needed; the counter follows the update rules above.

## Test plan
- Reset: hold `reset`=0 with both reqs high -> both grants 0, `vram_enable`=0, valids 0. Release -> CPU granted in the first cycle.
- CPU write then read: write 0xBEEF to 0x0010, then read 0x0010 -> `cpu_data_valid`=1 exactly one cycle after the read grant, `cpu_data_out`=0xBEEF; `dma_data_valid` stays 0.
- Contention, `MAX_BURST`=8, both reqs continuously high from idle -> CPU granted 8 cycles, DMA 8, CPU 8, …; no cycle has zero or two grants.
- DMA streaming, CPU idle for 20 cycles, then `cpu_req` rises -> CPU granted within 1 cycle (counter saturated).
- Interleaved reads: alternating CPU/DMA reads of 0x0001/0x0002 preloaded with 0x1111/0x2222 -> each valid lands on the correct side with the correct data, one cycle after its grant.
- Reset mid-read: assert `reset` in the cycle after a granted read -> no `*_data_valid` pulse appears.
